// File: rtl/adder_pkg.sv
// Shared encodings for the pipelined adder/subtractor.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_stage.sv
// One slice of the pipelined adder: adds its WIDTH/STAGES-bit slice plus the
// incoming carry and registers the result with the operands carried alongside.
module adder_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             carry_in,
    input  logic             op_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             op_out
);

    localparam int unsigned LO = IDX * SLICE;

    logic [SLICE:0]     slice_sum;
    logic [WIDTH-1:0]   sum_next;

    // Upstream stages leave this slice of sum_in at zero, so OR merges it in.
    always_comb begin
        slice_sum = {1'b0, a_in[LO +: SLICE]} + {1'b0, b_in[LO +: SLICE]}
                  + {{SLICE{1'b0}}, carry_in};
        sum_next  = sum_in | (WIDTH'(slice_sum[SLICE-1:0]) << LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
            op_out    <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            a_out     <= a_in;
            b_out     <= b_in;
            sum_out   <= sum_next;
            carry_out <= slice_sum[SLICE];
            op_out    <= op_in;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-linked slices.
// Define ADDER_PIPE_SAT_EN to clamp results on carry/borrow instead of wrapping.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_flag
);

    localparam int unsigned SLICE = WIDTH / STAGES;

    logic             valid_s [STAGES+1];
    logic [WIDTH-1:0] a_s     [STAGES+1];
    logic [WIDTH-1:0] b_s     [STAGES+1];
    logic [WIDTH-1:0] sum_s   [STAGES+1];
    logic             carry_s [STAGES+1];
    logic             op_s    [STAGES+1];

    logic             flag;

    assign in_ready = !out_valid || out_ready;

    // Subtract is A + ~B + 1: B is inverted here and the +1 rides in as carry-in.
    assign valid_s[0] = in_valid;
    assign op_s[0]    = in_valid & in_op;
    assign a_s[0]     = in_valid ? in_a : '0;
    assign b_s[0]     = !in_valid ? '0 : ((in_op == OP_SUB) ? ~in_b : in_b);
    assign carry_s[0] = (op_s[0] == OP_SUB);
    assign sum_s[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (in_ready),
            .valid_in  (valid_s[k]),
            .a_in      (a_s[k]),
            .b_in      (b_s[k]),
            .sum_in    (sum_s[k]),
            .carry_in  (carry_s[k]),
            .op_in     (op_s[k]),
            .valid_out (valid_s[k+1]),
            .a_out     (a_s[k+1]),
            .b_out     (b_s[k+1]),
            .sum_out   (sum_s[k+1]),
            .carry_out (carry_s[k+1]),
            .op_out    (op_s[k+1])
        );
    end

    assign out_valid = valid_s[STAGES];
    assign flag      = (op_s[STAGES] == OP_SUB) ? ~carry_s[STAGES] : carry_s[STAGES];
    assign out_flag  = flag;

`ifdef ADDER_PIPE_SAT_EN
    assign out_sum = !flag ? sum_s[STAGES] : ((op_s[STAGES] == OP_SUB) ? '0 : '1);
`else
    assign out_sum = sum_s[STAGES];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench: four adder_pipe instances (STAGES 1,2,4,8) share stimulus,
// each with its own expected-result queue; directed checks target STAGES=2.
module tb_adder_pipe;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid;
    logic         in_op;
    logic         out_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic         rdy [N];
    logic         ov  [N];
    logic         fl  [N];
    logic [W-1:0] sm  [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
        logic [W:0] r;
        logic       f;
        if (op) begin
            r = {1'b0, a} - {1'b0, b};
            f = (a < b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            f = r[W];
        end
`ifdef ADDER_PIPE_SAT_EN
        if (f) r[W-1:0] = op ? '0 : '1;
`endif
        return {f, r[W-1:0]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : lane
        localparam int unsigned STG = 1 << g;
        logic [W:0] q[$];
        logic [W:0] e;

        adder_pipe #(.WIDTH(W), .STAGES(STG)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_op     (in_op),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_sum   (sm[g]),
            .out_flag  (fl[g])
        );

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                check($sformatf("rst_valid_s%0d", STG), ov[g], 0);
                check($sformatf("rst_sum_s%0d", STG), sm[g], 0);
                check($sformatf("rst_flag_s%0d", STG), fl[g], 0);
            end else begin
                if (ov[g] && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("unexpected_out_s%0d", STG), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sum_s%0d", STG), sm[g], e[W-1:0]);
                        check($sformatf("flag_s%0d", STG), fl[g], e[W]);
                    end
                end
                if (in_valid && rdy[g]) q.push_back(model(in_a, in_b, in_op));
            end
        end
    end

    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic [W-1:0] es, input logic ef);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, ov[1], 0);
        @(negedge clk);
        check({tag, "_lat2"}, ov[1], 1);
        check({tag, "_sum"}, sm[1], es);
        check({tag, "_flag"}, fl[1], ef);
    endtask

    initial begin
        int         cnt;
        logic       acc;
        logic [W:0] frz;

        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", rdy[1], 1);

`ifdef ADDER_PIPE_SAT_EN
        single("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'hFF, 1'b1);
        single("sub_10_20", 8'h10, 8'h20, 1'b1, 8'h00, 1'b1);
`else
        single("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        single("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b1);
`endif
        single("sub_20_10", 8'h20, 8'h10, 1'b1, 8'h10, 1'b0);
        single("add_37_46", 8'h37, 8'h46, 1'b0, 8'h7D, 1'b0);

        // back-to-back: 16 beats, results expected on 16 consecutive cycles
        @(posedge clk); #1;
        cnt = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                in_valid = 1'b1; in_a = W'(i * 17); in_b = W'(8'hA5 ^ i); in_op = i[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 16) check("b2b_ready", rdy[1], 1);
            if (i >= 2) cnt += int'(ov[1]);
            @(posedge clk); #1;
        end
        check("b2b_count", cnt, 16);
        repeat (4) @(posedge clk);

        // backpressure: fill with out_ready low, then hold for 5 cycles
        #1 out_ready = 1'b0;
        frz = model(8'hC3, 8'h5A, 1'b0);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_a = W'(8'hC3 + k); in_b = W'(8'h5A - k); in_op = 1'b0;
            @(negedge clk);
            acc = rdy[1];
            @(posedge clk); #1;
            if (!acc) break;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", rdy[1], 0);
            check("bp_valid", ov[1], 1);
            check("bp_sum", sm[1], frz[W-1:0]);
            check("bp_flag", fl[1], frz[W]);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);

        // reset with two beats in flight
        #1;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 1'b0;
        @(posedge clk); #1;
        in_a = 8'h33; in_b = 8'h44; in_op = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", ov[1], 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", ov[1], 0);
        check("rst_async_sum", sm[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", rdy[1], 1);
        for (int c = 0; c < 6; c++) begin
            check("no_stale", ov[1], 0);
            @(negedge clk);
        end

        // random traffic with gaps on both sides
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_op     = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_s1", lane[0].q.size(), 0);
        check("drain_s2", lane[1].q.size(), 0);
        check("drain_s4", lane[2].q.size(), 0);
        check("drain_s8", lane[3].q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth (1..WIDTH, WIDTH divisible by STAGES).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  async active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand beat valid.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_a  input  WIDTH  operand A, unsigned.
REQ-009 SHALL have port in_b  input  WIDTH  operand B, unsigned.
REQ-010 SHALL have port in_op  input  1  0 = A+B, 1 = A-B.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_sum  output  WIDTH  result bits.
REQ-014 SHALL have port out_flag  output  1  carry/borrow, or saturation (see Configuration).

Function
REQ-015 SHALL split the operation into STAGES slices of WIDTH/STAGES bits; stage k computes slice k plus the carry from stage k-1, registered.
REQ-016 SHALL implement subtract as A + ~B + 1, the +1 injected as the stage-0 carry-in.
REQ-017 SHALL delay the unprocessed upper operand slices and op alongside each stage so every beat stays coherent.
REQ-018 SHALL have latency exactly STAGES cycles from accept to out_valid when not stalled.
REQ-019 SHALL sustain one beat per cycle when out_ready is held high.
REQ-020 SHALL stall all stages together: in_ready = !out_valid || out_ready; no stage advances when in_ready is 0.
REQ-021 SHALL hold out_sum, out_flag and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL insert a bubble (valid bit 0) into stage 0 when the pipeline advances with no input beat accepted.
REQ-023 SHALL drive out_flag = final carry for add and = inverted final carry (borrow) for subtract.
REQ-024 SHALL ignore in_a, in_b and in_op when in_valid is 0.

Reset
REQ-025 SHALL on rst assertion clear all stage valid bits, data registers, out_valid, out_sum and out_flag to 0 immediately, regardless of clk.
REQ-026 SHALL drop in-flight beats on reset mid-operation; none are output after release.
REQ-027 SHALL drive in_ready 1 in the first cycle after reset release.

Configuration
REQ-028 SHALL support macro ADDER_PIPE_SAT_EN.
REQ-029 SHALL, with ADDER_PIPE_SAT_EN defined, clamp out_sum to all ones on add carry and to 0 on subtract borrow, with out_flag = 1 only when clamping occurred.
REQ-030 SHALL, without ADDER_PIPE_SAT_EN, output wrapped modulo-2^WIDTH out_sum and carry/borrow on out_flag; the clamp logic SHALL not be present.

Structure
REQ-031 SHALL place the op encoding constants (OP_ADD = 0, OP_SUB = 1) in shared package adder_pkg.
REQ-032 SHALL use one sub-module adder_stage (one slice: registered sum, carry, valid, delayed operands), instantiated STAGES times with a generate loop.

Verification
REQ-033 SHALL verify with WIDTH=8, STAGES=2: add 0xFF+0x01 -> out_sum 0x00, out_flag 1 (0xFF, flag 1 with SAT_EN), out_valid two cycles after accept.
REQ-034 SHALL verify subtract 0x10-0x20 -> out_sum 0xF0, out_flag 1 (0x00, flag 1 with SAT_EN); subtract 0x20-0x10 -> 0x10, flag 0.
REQ-035 SHALL verify back-to-back: 16 beats with out_ready=1 -> 16 results in order on consecutive cycles, in_ready constantly 1.
REQ-036 SHALL verify backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready 0, outputs frozen; release -> no beat lost or duplicated.
REQ-037 SHALL verify reset mid-stream: assert rst with 2 beats in flight -> out_valid 0 at once, no stale result after release.
REQ-038 SHALL verify random operands and ops, gaps on in_valid and out_ready, against a reference model for STAGES in {1,2,4,8}.
